id_ex_stage: RTL

- Pipeline register between instruction decode and the ALU.
- Captures decoded operands, immediate, destination and control fields on each clock.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then presents final A/B operands and the 4-bit ALU operation to the ALU.
- Detects load-use hazards, requests a decode stall and inserts a bubble.

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// It also detects load-use hazards, requests a decode stall and inserts a bubble.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [3:0]                alu_op_i,
  input  logic                      alu_src_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic                      mem_to_reg_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      exmem_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     exmem_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                      memwb_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     memwb_data_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      stall_req_o,
  output logic                      valid_o,
  output logic [3:0]                alu_op_o,
  output logic [DATA_WIDTH-1:0]     A_o,
  output logic [DATA_WIDTH-1:0]     B_o,
  output logic [DATA_WIDTH-1:0]     store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic                      mem_to_reg_o
);

  logic                      r_valid;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]     r_rs1_data;
  logic [DATA_WIDTH-1:0]     r_rs2_data;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [3:0]                r_alu_op;
  logic                      r_alu_src;
  logic                      r_reg_write;
  logic                      r_mem_read;
  logic                      r_mem_write;
  logic                      r_mem_to_reg;

  logic                      w_load_use;
  logic [DATA_WIDTH-1:0]     w_fwd_a;
  logic [DATA_WIDTH-1:0]     w_fwd_b;

  // A load in EX whose rd is read by the instruction in decode cannot be forwarded in time.
  assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && valid_i &&
                      ((r_rd == rs1_addr_i) || (r_rd == rs2_addr_i));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_alu_op     <= 4'b0000;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (flush_i || (!stall_i && w_load_use)) begin
      // Flush and load-use bubble both kill the slot; operand fields are don't-care.
      r_valid      <= 1'b0;
      r_alu_op     <= 4'b0000;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!stall_i) begin
      r_valid      <= valid_i;
      r_rs1        <= rs1_addr_i;
      r_rs2        <= rs2_addr_i;
      r_rd         <= rd_addr_i;
      r_rs1_data   <= rs1_data_i;
      r_rs2_data   <= rs2_data_i;
      r_imm        <= imm_i;
      r_alu_op     <= alu_op_i;
      r_alu_src    <= alu_src_i;
      r_reg_write  <= reg_write_i;
      r_mem_read   <= mem_read_i;
      r_mem_write  <= mem_write_i;
      r_mem_to_reg <= mem_to_reg_i;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 always reads its register value.
  always_comb begin
    w_fwd_a = r_rs1_data;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == r_rs1))
      w_fwd_a = exmem_result_i;
    else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == r_rs1))
      w_fwd_a = memwb_data_i;

    w_fwd_b = r_rs2_data;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == r_rs2))
      w_fwd_b = exmem_result_i;
    else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == r_rs2))
      w_fwd_b = memwb_data_i;
  end

  assign A_o          = w_fwd_a;
  assign B_o          = r_alu_src ? r_imm : w_fwd_b;
  assign store_data_o = w_fwd_b;
  assign stall_req_o  = w_load_use;
  assign valid_o      = r_valid;
  assign alu_op_o     = r_alu_op;
  assign rd_addr_o    = r_rd;
  assign reg_write_o  = r_valid & r_reg_write;
  assign mem_read_o   = r_valid & r_mem_read;
  assign mem_write_o  = r_valid & r_mem_write;
  assign mem_to_reg_o = r_valid & r_mem_to_reg;

endmodule
